// File: rtl/input_sync_debounce.sv
// -----------------------------------------------------------------------------
// input_sync_debounce
//
// Multi-channel conditioner for asynchronous board inputs (switches, buttons,
// GPIO). Each channel passes through a SYNC_STAGES-deep synchroniser, then a
// debounce filter, and produces registered rise/fall event pulses.
//
// Optional feature macro: INPUT_SYNC_DEBOUNCE_EN
//   defined   : per-channel debounce counters are built; level changes only
//               after DEBOUNCE_CYCLES consecutive cycles of disagreement.
//   undefined : counters are removed; level follows the synchroniser output
//               with one register of delay; DEBOUNCE_CYCLES is unused.
//
// Ports:
//   clk        in   1       single system clock
//   reset      in   1       asynchronous, active-low reset
//   in_raw     in   NUM_CH  asynchronous raw inputs
//   level      out  NUM_CH  synchronised, debounced input state
//   rise       out  NUM_CH  one-cycle pulse when level[i] goes 0->1
//   fall       out  NUM_CH  one-cycle pulse when level[i] goes 1->0
//   any_event  out  1       one-cycle pulse when any rise/fall bit is set
//
// All outputs come straight from flops; no combinational path from in_raw.
// -----------------------------------------------------------------------------
module input_sync_debounce #(
    parameter int                 NUM_CH          = 4,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter logic [NUM_CH-1:0]  RESET_VAL       = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] in_raw,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              any_event
);

    // Reject unsupported configurations at elaboration time.
    if ((NUM_CH < 1) || (NUM_CH > 32) || (SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 1)) begin : g_bad_param
        $error("input_sync_debounce: unsupported parameter combination");
    end

    // Synchroniser chain: stage 0 samples in_raw, last stage is the sync output.
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]                  sync_s;

    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] rise_q,  rise_d;
    logic [NUM_CH-1:0] fall_q,  fall_d;
    logic              any_q,   any_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Plain flop chain per channel, no logic between the stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q[0] <= in_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

`ifdef INPUT_SYNC_DEBOUNCE_EN
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Debounce decision: count consecutive disagreement cycles; the cycle that
    // would complete the run commits the new value instead of counting further,
    // so the counter never needs to hold DEBOUNCE_CYCLES itself.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sync_s[ch] == level_q[ch]) begin
                cnt_d[ch] = {CNT_W{1'b0}};
            end else if (cnt_q[ch] == CNT_LAST) begin
                level_d[ch] = sync_s[ch];
                cnt_d[ch]   = {CNT_W{1'b0}};
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    // Debounce counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {(NUM_CH*CNT_W){1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without debouncing the level simply tracks the synchroniser output.
    always_comb begin
        level_d = sync_s;
    end
`endif

    // Edge events are taken from the level transition that is about to be
    // registered, so the pulse appears in the same cycle as the new level.
    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
        any_d  = |(rise_d | fall_d);
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= RESET_VAL;
            rise_q  <= {NUM_CH{1'b0}};
            fall_q  <= {NUM_CH{1'b0}};
            any_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
        end
    end

    assign level     = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign any_event = any_q;

endmodule
